// File: rtl/arb_pkg.sv
// ============================================================================
// Module  : arb_pkg
// Purpose : Shared types and default widths for the unified-memory arbiter.
//           state_t - arbiter FSM states
//           owner_t - which requester owns the in-flight transaction
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int MAX_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one single-ported memory between instruction fetch (i)
//           and load/store (d). One transaction at a time: IDLE accepts a
//           request, REQ holds it on the memory bus until m_gnt, RESP waits
//           for m_rvalid and routes it to the owner. Data wins contention,
//           except that after MAX_STREAK back-to-back data grants with a
//           fetch pending the fetch is served. i_flush drops the response of
//           an in-flight fetch.
// Ports   :
//   clk, rst                     clock, asynchronous active-low reset
//   i_req/i_addr/i_flush         fetch request, address, response discard
//   i_ready/i_rvalid/i_rdata     fetch accept pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata    data request payload
//   d_ready/d_rvalid/d_rdata     data accept pulse, response pulse, data
//   m_req/m_we/m_addr/m_wdata    memory request
//   m_gnt/m_rvalid/m_rdata       memory grant and response
//   busy                         transaction in flight (state != IDLE)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  // status
  output logic              busy
);

  // Wide enough to hold the value MAX_STREAK itself.
  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  state_t            state_q,  state_d;
  owner_t            owner_q,  owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              drop_q,   drop_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              we_q,     we_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;

  logic win_d;
  logic win_i;
  logic flush_hit;

  // Data wins unless a fetch is waiting and data has used up its streak.
  assign win_d = d_req & (~i_req | (streak_q != STREAK_MAX));
  assign win_i = i_req & ~win_d;

  // A flush only matters while a fetch owns the bus.
  assign flush_hit = i_flush & (owner_q == OWN_I) & (state_q != IDLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      streak_q <= '0;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    drop_d   = drop_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE: begin
        if (win_d) begin
          state_d = REQ;
          owner_d = OWN_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          // Streak only grows while a fetch is actually being held off.
          if (i_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (win_i) begin
          state_d  = REQ;
          owner_d  = OWN_I;
          addr_d   = i_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          streak_d = '0;
        end
      end

      REQ: begin
        if (flush_hit) drop_d = 1'b1;
        if (m_gnt)     state_d = RESP;
      end

      RESP: begin
        if (flush_hit) drop_d = 1'b1;
        if (m_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = addr_q;
    m_wdata  = wdata_q;
    busy     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        i_ready = win_i;
        d_ready = win_d;
      end
      REQ: begin
        m_req = 1'b1;
        m_we  = we_q;
      end
      RESP: begin
        if (owner_q == OWN_D) begin
          d_rvalid = m_rvalid;
        end else begin
          // The same-cycle flush also suppresses, not only the latched one.
          i_rvalid = m_rvalid & ~drop_q & ~i_flush;
        end
      end
      default: ;
    endcase

    // Read data is a passthrough, held at zero when not qualified.
    if (i_rvalid) i_rdata = m_rdata;
    if (d_rvalid) d_rdata = m_rdata;
  end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed self-checking bench for mem_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_STREAK = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, i_flush;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt, m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_flush (i_flush),
    .i_ready (i_ready),
    .i_rvalid(i_rvalid),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ready (d_ready),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_gnt   (m_gnt),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Illegal stimulus: flush in the same cycle a fetch is accepted.
  always @(negedge clk) begin
    if (rst && i_ready && i_flush) check_eq("flush_with_ready", 32'd1, 32'd0);
  end

  // Protocol notes for responses/grants the arbiter is expected to ignore.
  always @(negedge clk) begin
    if (rst && m_rvalid && !busy) $display("note: m_rvalid with no transaction, ignored");
    if (rst && m_gnt && !m_req)   $display("note: m_gnt without m_req, ignored");
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  logic       exp_d_order [10];
  logic [31:0] load_data  [3];

  initial begin
    rst = 1'b0; i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    exp_d_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    load_data   = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008};

    // ---------------- reset state ----------------
    #2;
    check_eq("rst_busy",  {31'd0, busy},  32'd0);
    check_eq("rst_m_req", {31'd0, m_req}, 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    check_eq("rst_m_wdata", m_wdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    next_cycle();

    // ---------------- lone fetch ----------------
    i_req = 1; i_addr = 32'h100;
    sample();
    check_eq("fetch_i_ready", {31'd0, i_ready}, 32'd1);
    check_eq("fetch_d_ready", {31'd0, d_ready}, 32'd0);
    check_eq("fetch_c0_m_req", {31'd0, m_req}, 32'd0);
    next_cycle();
    i_req = 0; m_gnt = 1;
    sample();
    check_eq("fetch_c1_m_req", {31'd0, m_req}, 32'd1);
    check_eq("fetch_c1_m_addr", m_addr, 32'h100);
    check_eq("fetch_c1_m_we", {31'd0, m_we}, 32'd0);
    next_cycle();
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0050_0093;
    sample();
    check_eq("fetch_c2_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check_eq("fetch_c2_i_rdata", i_rdata, 32'h0050_0093);
    check_eq("fetch_c2_m_req", {31'd0, m_req}, 32'd0);
    next_cycle();
    m_rvalid = 0;
    sample();
    check_eq("fetch_done_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // ---------------- store with delayed grant ----------------
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    sample();
    check_eq("store_d_ready", {31'd0, d_ready}, 32'd1);
    next_cycle();
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int c = 0; c < 4; c++) begin
      m_gnt = (c == 3);
      sample();
      check_eq("store_m_req", {31'd0, m_req}, 32'd1);
      check_eq("store_m_we", {31'd0, m_we}, 32'd1);
      check_eq("store_m_addr", m_addr, 32'h2000);
      check_eq("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
      next_cycle();
    end
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0;
    sample();
    check_eq("store_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_eq("store_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check_eq("store_i_ready",  {31'd0, i_ready},  32'd0);
    next_cycle();
    m_rvalid = 0;

    // ---------------- contention ----------------
    i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
    for (int k = 0; k < 10; k++) begin
      sample();
      check_eq("cont_d_ready", {31'd0, d_ready}, {31'd0, exp_d_order[k]});
      check_eq("cont_i_ready", {31'd0, i_ready}, {31'd0, ~exp_d_order[k]});
      next_cycle();
      m_gnt = 1;
      next_cycle();
      m_gnt = 0; m_rvalid = 1; m_rdata = 32'(k);
      sample();
      if (exp_d_order[k]) check_eq("cont_d_rvalid", {31'd0, d_rvalid}, 32'd1);
      else                check_eq("cont_i_rvalid", {31'd0, i_rvalid}, 32'd1);
      next_cycle();
      m_rvalid = 0;
    end
    i_req = 0; d_req = 0;
    next_cycle();

    // ---------------- flush ----------------
    i_req = 1; i_addr = 32'h104;
    sample();
    check_eq("flush_i_ready", {31'd0, i_ready}, 32'd1);
    next_cycle();
    i_req = 0; m_gnt = 1;
    next_cycle();
    m_gnt = 0; i_flush = 1;
    sample();
    check_eq("flush_resp_busy", {31'd0, busy}, 32'd1);
    next_cycle();
    i_flush = 0;
    next_cycle();
    m_rvalid = 1; m_rdata = 32'hBADB_AD00;
    sample();
    check_eq("flush_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check_eq("flush_i_rdata", i_rdata, 32'd0);
    next_cycle();
    m_rvalid = 0;
    sample();
    check_eq("flush_done_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    i_req = 1; i_addr = 32'h200;
    sample();
    check_eq("refetch_i_ready", {31'd0, i_ready}, 32'd1);
    next_cycle();
    i_req = 0; m_gnt = 1;
    sample();
    check_eq("refetch_m_addr", m_addr, 32'h200);
    next_cycle();
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1234_5678;
    sample();
    check_eq("refetch_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check_eq("refetch_i_rdata", i_rdata, 32'h1234_5678);
    next_cycle();
    m_rvalid = 0;
    next_cycle();

    // ---------------- reset mid-transaction ----------------
    d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hCAFE_F00D;
    sample();
    check_eq("rstop_d_ready", {31'd0, d_ready}, 32'd1);
    next_cycle();
    d_req = 0; d_we = 0; m_gnt = 1;
    next_cycle();
    m_gnt = 0;
    sample();
    check_eq("rstop_resp_busy", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b0; m_rvalid = 1; m_rdata = 32'hAAAA_5555;
    #1;
    check_eq("rstop_busy", {31'd0, busy}, 32'd0);
    check_eq("rstop_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check_eq("rstop_m_addr", m_addr, 32'd0);
    check_eq("rstop_m_wdata", m_wdata, 32'd0);
    check_eq("rstop_m_req", {31'd0, m_req}, 32'd0);
    next_cycle();
    rst = 1'b1;
    sample();
    check_eq("stray_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check_eq("stray_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check_eq("stray_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    m_rvalid = 0;
    next_cycle();

    // ---------------- back-to-back loads ----------------
    d_req = 1; d_we = 0;
    for (int k = 0; k < 3; k++) begin
      d_addr = 32'(4 * k);
      sample();
      check_eq("b2b_d_ready", {31'd0, d_ready}, 32'd1);
      next_cycle();
      if (k == 2) d_req = 0;
      m_gnt = 1;
      sample();
      check_eq("b2b_req_d_ready", {31'd0, d_ready}, 32'd0);
      check_eq("b2b_m_addr", m_addr, 32'(4 * k));
      check_eq("b2b_m_we", {31'd0, m_we}, 32'd0);
      next_cycle();
      m_gnt = 0; m_rvalid = 1; m_rdata = load_data[k];
      sample();
      check_eq("b2b_d_rvalid", {31'd0, d_rvalid}, 32'd1);
      check_eq("b2b_d_rdata", d_rdata, load_data[k]);
      check_eq("b2b_resp_d_ready", {31'd0, d_ready}, 32'd0);
      next_cycle();
      m_rvalid = 0;
    end
    sample();
    check_eq("b2b_done_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire
